sync_decoder: RTL

SYNC_DECODER -- requirements
Module: sync_decoder

---
 rtl/sync_decoder_if.sv | 22 ++
 rtl/sync_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_decoder_if.sv
// Sync decoder bus: raw sync inputs in, timing/lock status out.
// Signals: HSync, VSync (active-low) -> Col, Row, LineLen, Locked, HErr, FrameErr.
interface sync_decoder_if;
    logic       HSync;
    logic       VSync;
    logic [9:0] Col;
    logic [9:0] Row;
    logic [9:0] LineLen;
    logic       Locked;
    logic       HErr;
    logic       FrameErr;

    modport master (
        output HSync, VSync,
        input  Col, Row, LineLen, Locked, HErr, FrameErr
    );

    modport slave (
        input  HSync, VSync,
        output Col, Row, LineLen, Locked, HErr, FrameErr
    );
endinterface

// File: rtl/sync_decoder.sv
// Video sync decoder: column/row counters, line-length measure, line lock FSM.
// Ports: CLK, ResetN (async low), bus (slave). Macro SYNC_DECODER_VCHECK_EN adds frame check.
module sync_decoder #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int LOCK_LINES = 4
) (
    input  logic        CLK,
    input  logic        ResetN,
    sync_decoder_if.slave bus
);

    if (LOCK_LINES < 1 || LOCK_LINES > 15 || V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad
        $error("sync_decoder: parameter out of range");
    end

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [3:0]  LL = 4'(LOCK_LINES);

    state_t      state, state_n;
    logic [3:0]  good, good_n;
    logic        herr, herr_n;
    logic        hs_q, vs_q;
    logic        hs_edge, vs_edge;
    logic [9:0]  col, row, linelen;
    logic [10:0] col_p1;
    logic [3:0]  good_p1;
    logic        line_ok, col_max, locked;

    assign hs_edge = hs_q & ~bus.HSync;
    assign vs_edge = vs_q & ~bus.VSync;
    assign col_p1  = {1'b0, col} + 11'd1;
    assign good_p1 = good + 4'd1;
    assign line_ok = (col_p1 == HT);
    assign col_max = (col == 10'h3FF);
    assign locked  = (state == LOCKED);

    // Sync registers idle high so a low input right after reset is an edge.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= bus.HSync;
            vs_q <= bus.VSync;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            col     <= '0;
            linelen <= '0;
        end else if (hs_edge) begin
            col     <= '0;
            linelen <= col_p1[10] ? 10'h3FF : col_p1[9:0];
        end else if (!col_max) begin
            col <= col + 10'd1;
        end
    end

    // VSync wins when both edges land in the same cycle.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            row <= '0;
        end else if (vs_edge) begin
            row <= '0;
        end else if (hs_edge && row != 10'h3FF) begin
            row <= row + 10'd1;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state <= SEARCH;
            good  <= '0;
            herr  <= 1'b0;
        end else begin
            state <= state_n;
            good  <= good_n;
            herr  <= herr_n;
        end
    end

    // A saturated column with no edge means the line timing is lost.
    always_comb begin
        state_n = state;
        good_n  = good;
        herr_n  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (hs_edge) begin
                    state_n = CHECK;
                    good_n  = '0;
                end
            end
            CHECK: begin
                if (hs_edge) begin
                    if (line_ok) begin
                        good_n = good_p1;
                        if (good_p1 == LL) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        good_n = '0;
                    end
                end else if (col_max) begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            LOCKED: begin
                if (hs_edge) begin
                    if (!line_ok) begin
                        herr_n  = 1'b1;
                        state_n = CHECK;
                        good_n  = '0;
                    end
                end else if (col_max) begin
                    herr_n  = 1'b1;
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            default: begin
                state_n = SEARCH;
                good_n  = '0;
            end
        endcase
    end

`ifdef SYNC_DECODER_VCHECK_EN
    localparam logic [10:0] VT = 11'(V_TOTAL);

    logic        armed;
    logic        ferr;
    logic [10:0] row_p1;

    assign row_p1 = {1'b0, row} + 11'd1;

    // The first VSync after lock only arms the check; its frame is partial.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            armed <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            ferr <= vs_edge & locked & armed & (row_p1 != VT);
            if (!locked) begin
                armed <= 1'b0;
            end else if (vs_edge) begin
                armed <= 1'b1;
            end
        end
    end

    assign bus.FrameErr = ferr;
`else
    assign bus.FrameErr = 1'b0;
`endif

    assign bus.Col     = col;
    assign bus.Row     = row;
    assign bus.LineLen = linelen;
    assign bus.Locked  = locked;
    assign bus.HErr    = herr;

endmodule
